leaf_egress_buffer: RTL and testbench

- Egress stage between the leaf's stream flow control (its `stream_out` and `resend` pins) and the BFT switch input port of that leaf.
- Captures every valid packet the flow control emits into a small FIFO and presents the head to the switch until the switch accepts it.
- When the FIFO is full it asserts `resend`, so the flow control re-presents the same packet on the next cycle.
- Also keeps two saturating performance counters: packets sent and backpressure cycles.

---
 rtl/leaf_egress_pkg.sv | 23 ++
 rtl/egress_fifo.sv | 78 +++++++
 rtl/leaf_egress_buffer.sv | 87 ++++++++
 tb/tb_leaf_egress_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/leaf_egress_pkg.sv
// Shared definitions for the leaf egress buffer: packet field offsets and helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package leaf_egress_pkg;

  // Default packet geometry; the modules take these as parameter defaults.
  localparam int PKT_BITS_DFLT  = 97;
  localparam int LEAF_BITS_DFLT = 6;
  localparam int PORT_BITS_DFLT = 4;

  // Field offsets. The valid flag is the MSB. The leaf field sits directly
  // below it, and the port field sits directly below the leaf field. The leaf
  // and port fields exist for debug visibility only; the buffer never routes on them.
  localparam int VALID_BIT = PKT_BITS_DFLT - 1;
  localparam int LEAF_MSB  = PKT_BITS_DFLT - 2;
  localparam int PORT_MSB  = LEAF_MSB - LEAF_BITS_DFLT;

  // Valid flag of a default-width packet.
  function automatic logic pkt_valid(input logic [PKT_BITS_DFLT-1:0] pkt);
    return pkt[VALID_BIT];
  endfunction

endpackage

// File: rtl/egress_fifo.sv
// Synchronous FIFO holding egress packets: storage, read/write pointers, occupancy, full flag.
// Latency: a write is visible on rd_data_o from the cycle after the push.
// Backpressure: the caller must not push while full_o=1; a pop on an empty FIFO is ignored.
module egress_fifo
  import leaf_egress_pkg::*;
#(
  parameter int WIDTH = PKT_BITS_DFLT,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             do_pop;

  // A pop only takes effect when there is something to pop.
  assign do_pop = pop_i & (count_q != '0);

  // Next-state pointers, occupancy and full flag; the pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_i && !do_pop) begin
      count_d = count_q + LW'(1);
    end else if (!push_i && do_pop) begin
      count_d = count_q - LW'(1);
    end
    full_d = (count_d == LW'(DEPTH));
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage write; contents are not reset because an empty FIFO never exposes them.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = full_q;

endmodule

// File: rtl/leaf_egress_buffer.sv
// Egress buffer between the leaf flow control and the BFT switch input, with performance counters.
// Latency: a packet pushed into an empty buffer appears on stream_out one cycle later.
// Backpressure: while full, valid input is refused and resend=1; upstream re-presents the packet the next cycle.
module leaf_egress_buffer
  import leaf_egress_pkg::*;
#(
  parameter int PACKET_BITS   = PKT_BITS_DFLT,
  parameter int NUM_LEAF_BITS = LEAF_BITS_DFLT,
  parameter int NUM_PORT_BITS = PORT_BITS_DFLT,
  parameter int DEPTH         = 4,
  parameter int CNT_BITS      = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [PACKET_BITS-1:0]   stream_in,
  output logic                     resend,
  output logic [PACKET_BITS-1:0]   stream_out,
  input  logic                     sw_accept,
  output logic [CNT_BITS-1:0]      pkt_sent_cnt,
  output logic [CNT_BITS-1:0]      bp_cycle_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic                   in_vld;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic [LW-1:0]          count;
  logic [PACKET_BITS-1:0] head;
  logic [CNT_BITS-1:0]    pkt_sent_q, pkt_sent_d;
  logic [CNT_BITS-1:0]    bp_cnt_q, bp_cnt_d;

  // Only the valid flag is inspected. Resend comes only from the registered full
  // flag, so a pop in a full cycle still refuses the push. The freed slot is
  // usable from the next cycle.
  assign in_vld = stream_in[PACKET_BITS-1];
  assign push   = in_vld & ~full;
  assign pop    = (count != '0) & sw_accept;
  assign resend = in_vld & full;

  egress_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (push),
    .wr_data_i (stream_in),
    .pop_i     (pop),
    .rd_data_o (head),
    .count_o   (count),
    .full_o    (full)
  );

  // Never expose storage while empty; this also hides stale data right after reset.
  assign stream_out = (count != '0) ? head : '0;
  assign fifo_level = count;

  // Saturating next-count for the sent-packet and backpressure-cycle counters.
  always_comb begin
    pkt_sent_d = pkt_sent_q;
    bp_cnt_d   = bp_cnt_q;
    if (pop && (pkt_sent_q != '1)) begin
      pkt_sent_d = pkt_sent_q + CNT_BITS'(1);
    end
    if (resend && (bp_cnt_q != '1)) begin
      bp_cnt_d = bp_cnt_q + CNT_BITS'(1);
    end
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_sent_q <= '0;
      bp_cnt_q   <= '0;
    end else begin
      pkt_sent_q <= pkt_sent_d;
      bp_cnt_q   <= bp_cnt_d;
    end
  end

  assign pkt_sent_cnt = pkt_sent_q;
  assign bp_cycle_cnt = bp_cnt_q;

endmodule

// File: tb/tb_leaf_egress_buffer.sv
// Directed self-checking bench for leaf_egress_buffer.
// Latency: n/a.
// Backpressure: n/a.
module tb_leaf_egress_buffer;
  import leaf_egress_pkg::*;

  localparam int PB = 97;
  localparam int CB = 32;

  logic          clk;
  logic          reset_n;
  logic [PB-1:0] stream_in;
  logic          resend;
  logic [PB-1:0] stream_out;
  logic          sw_accept;
  logic [CB-1:0] pkt_sent_cnt;
  logic [CB-1:0] bp_cycle_cnt;
  logic [2:0]    fifo_level;

  int checks = 0;
  int errors = 0;

  leaf_egress_buffer #(
    .PACKET_BITS   (PB),
    .NUM_LEAF_BITS (6),
    .NUM_PORT_BITS (4),
    .DEPTH         (4),
    .CNT_BITS      (CB)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stream_in    (stream_in),
    .resend       (resend),
    .stream_out   (stream_out),
    .sw_accept    (sw_accept),
    .pkt_sent_cnt (pkt_sent_cnt),
    .bp_cycle_cnt (bp_cycle_cnt),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Valid packet with a distinct, tag-derived payload.
  function automatic logic [PB-1:0] mkpkt(input logic [7:0] tag);
    return {1'b1, {12{tag}}};
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PB-1:0] pab;
    logic [PB-1:0] a [5];

    pab = 97'h1_0000_0000_0000_0000_0000_00AB;
    for (int k = 0; k < 5; k++) a[k] = mkpkt(8'h10 + 8'(k));

    // Test 1: reset state with a valid packet presented
    reset_n   = 1'b0;
    sw_accept = 1'b0;
    stream_in = pab;
    tick(); tick();
    chk("pkt_valid_helper", 128'(pkt_valid(pab)), 128'(1));
    chk("rst_stream_out", 128'(stream_out), 128'(0));
    chk("rst_resend", 128'(resend), 128'(0));
    chk("rst_pkt_cnt", 128'(pkt_sent_cnt), 128'(0));
    chk("rst_bp_cnt", 128'(bp_cycle_cnt), 128'(0));
    chk("rst_level", 128'(fifo_level), 128'(0));

    @(negedge clk);
    reset_n = 1'b1;
    tick();
    stream_in = '0;
    chk("t1_head", 128'(stream_out), 128'(pab));
    chk("t1_level", 128'(fifo_level), 128'(1));
    sw_accept = 1'b1;
    tick();
    sw_accept = 1'b0;
    chk("t1_drained_level", 128'(fifo_level), 128'(0));
    chk("t1_drained_out", 128'(stream_out), 128'(0));
    chk("t1_pkt_cnt", 128'(pkt_sent_cnt), 128'(1));

    // Test 2: fill to four, then hold a fifth against backpressure
    for (int k = 0; k < 4; k++) begin
      stream_in = a[k];
      #1;
      chk("t2_fill_resend", 128'(resend), 128'(0));
      tick();
    end
    chk("t2_level_full", 128'(fifo_level), 128'(4));
    chk("t2_head", 128'(stream_out), 128'(a[0]));
    stream_in = a[4];
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_resend_held", 128'(resend), 128'(1));
      tick();
      chk("t2_bp_cnt", 128'(bp_cycle_cnt), 128'(k + 1));
      chk("t2_level_held", 128'(fifo_level), 128'(4));
    end

    // Test 3: pop while full refuses the push; retry succeeds next cycle
    sw_accept = 1'b1;
    #1;
    chk("t3_resend_pop_full", 128'(resend), 128'(1));
    tick();
    chk("t3_level3", 128'(fifo_level), 128'(3));
    chk("t3_head_a1", 128'(stream_out), 128'(a[1]));
    chk("t3_pkt_cnt", 128'(pkt_sent_cnt), 128'(2));
    chk("t3_bp_cnt", 128'(bp_cycle_cnt), 128'(4));
    sw_accept = 1'b0;
    #1;
    chk("t3_retry_resend", 128'(resend), 128'(0));
    tick();
    stream_in = '0;
    chk("t3_level4", 128'(fifo_level), 128'(4));
    chk("t3_bp_hold", 128'(bp_cycle_cnt), 128'(4));
    sw_accept = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("t3_drain_order", 128'(stream_out), 128'(a[k]));
      tick();
    end
    sw_accept = 1'b0;
    chk("t3_empty_level", 128'(fifo_level), 128'(0));
    chk("t3_empty_out", 128'(stream_out), 128'(0));
    chk("t3_pkt_cnt_after", 128'(pkt_sent_cnt), 128'(6));

    // Test 4: 20 back-to-back packets with the switch always accepting
    sw_accept = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stream_in = mkpkt(8'h40 + 8'(i));
      #1;
      chk("t4_resend", 128'(resend), 128'(0));
      tick();
      chk("t4_order", 128'(stream_out), 128'(mkpkt(8'h40 + 8'(i))));
      chk("t4_level", 128'(fifo_level), 128'(1));
    end
    stream_in = '0;
    tick();
    sw_accept = 1'b0;
    chk("t4_level_end", 128'(fifo_level), 128'(0));
    chk("t4_pkt_cnt", 128'(pkt_sent_cnt), 128'(26));
    chk("t4_bp_cnt", 128'(bp_cycle_cnt), 128'(4));

    // Test 5: invalid packets with nonzero payload are never captured
    for (int i = 0; i < 10; i++) begin
      stream_in = {1'b0, {12{8'hC3 + 8'(i)}}};
      sw_accept = i[0];
      #1;
      chk("t5_resend", 128'(resend), 128'(0));
      tick();
      chk("t5_level", 128'(fifo_level), 128'(0));
      chk("t5_out", 128'(stream_out), 128'(0));
    end
    sw_accept = 1'b0;

    // Test 6: asynchronous reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      stream_in = mkpkt(8'h80 + 8'(k));
      tick();
    end
    stream_in = mkpkt(8'h83);
    chk("t6_level3", 128'(fifo_level), 128'(3));
    chk("t6_head", 128'(stream_out), 128'(mkpkt(8'h80)));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_out", 128'(stream_out), 128'(0));
    chk("t6_async_level", 128'(fifo_level), 128'(0));
    chk("t6_async_resend", 128'(resend), 128'(0));
    chk("t6_async_pkt_cnt", 128'(pkt_sent_cnt), 128'(0));
    chk("t6_async_bp_cnt", 128'(bp_cycle_cnt), 128'(0));
    tick();
    @(negedge clk);
    stream_in = '0;
    sw_accept = 1'b1;
    reset_n   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_stale", 128'(stream_out), 128'(0));
    end
    sw_accept = 1'b0;
    stream_in = mkpkt(8'h99);
    tick();
    stream_in = '0;
    chk("t6_fresh_head", 128'(stream_out), 128'(mkpkt(8'h99)));
    chk("t6_fresh_level", 128'(fifo_level), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
